mem_stage_sram_ctrl: RTL and testbench



---
 rtl/mem_stage_sram_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// Load/store responder: each 32-bit access runs as two 16-bit SRAM phases; MEM_FAULT_EN adds address checking.
// Latency: 2*WAIT_CYCLES+1 cycles from request to the completion cycle (1 cycle when an access faults).
// Backpressure: ready is low from the request cycle until completion; new requests are taken only in IDLE.
module mem_stage_sram_ctrl #(
   parameter int WAIT_CYCLES = 2,
   parameter int BASE_ADDR   = 1024,
   parameter int SRAM_ADDR_W = 18
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic                   wr_en,
   input  logic [31:0]            addr,
   input  logic [31:0]            wdata,
   output logic [31:0]            rdata,
   output logic                   ready,
   output logic                   fault,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic                   sram_we_n,
   output logic [15:0]            sram_dq_o,
   output logic                   sram_dq_oe,
   input  logic [15:0]            sram_dq_i
);

   localparam int IW = SRAM_ADDR_W - 1;
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
   localparam logic [31:0]   BASE     = 32'(BASE_ADDR);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          req;
   logic          phase_end;
   logic          active;
   logic          acc_fault;
   logic [31:0]   offset;
   logic [IW-1:0] acc_idx;
   logic [IW-1:0] idx_q;
   logic          op_wr_q;
   logic [15:0]   wdata_hi_q;
   logic [15:0]   rdata_lo_q;

   assign req       = rd_en | wr_en;
   assign offset    = addr - BASE;
   assign acc_idx   = offset[IW+1:2];
   assign phase_end = (cnt == CNT_LAST);
   assign active    = (state == LO) || (state == HI);

`ifdef MEM_FAULT_EN
   logic fault_q;
   logic unused_offset_bits;

   assign acc_fault          = (addr[1:0] != 2'b00) || (addr < BASE) || (|offset[31:IW+2]);
   assign fault              = fault_q;
   assign unused_offset_bits = ^offset[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= (state == IDLE) && req && acc_fault;
      end
   end
`else
   logic unused_addr_bits;

   // Misaligned and out-of-range addresses silently wrap onto the SRAM.
   assign acc_fault        = 1'b0;
   assign fault            = 1'b0;
   assign unused_addr_bits = ^{offset[31:IW+2], offset[1:0]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (active && !phase_end) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req) state_nx = acc_fault ? DONE : LO;
         LO:      if (phase_end) state_nx = HI;
         HI:      if (phase_end) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign ready      = ((state == IDLE) && !req) || (state == DONE);
   assign sram_we_n  = !(active && op_wr_q);
   assign sram_dq_oe = active && op_wr_q;

   // Address and write data are registered one phase ahead so they are stable for the whole phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata      <= '0;
         rdata_lo_q <= '0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         op_wr_q    <= 1'b0;
         idx_q      <= '0;
         wdata_hi_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req && !acc_fault) begin
                  op_wr_q    <= wr_en;
                  idx_q      <= acc_idx;
                  wdata_hi_q <= wdata[31:16];
                  sram_addr  <= {acc_idx, 1'b0};
                  if (wr_en) sram_dq_o <= wdata[15:0];
               end
            end
            LO: begin
               if (phase_end) begin
                  sram_addr <= {idx_q, 1'b1};
                  if (op_wr_q) begin
                     sram_dq_o <= wdata_hi_q;
                  end else begin
                     rdata_lo_q <= sram_dq_i;
                  end
               end
            end
            HI: begin
               if (phase_end && !op_wr_q) rdata <= {sram_dq_i, rdata_lo_q};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: SRAM model, transaction-timeline reference model, directed and random requests.
module tb_mem_stage_sram_ctrl;
   localparam int W    = 2;
   localparam int BASE = 1024;
   localparam int AW   = 18;

   logic            clk = 1'b0;
   logic            rst, rd_en, wr_en;
   logic [31:0]     addr, wdata, rdata;
   logic            ready, fault;
   logic [AW-1:0]   sram_addr;
   logic            sram_we_n, sram_dq_oe;
   logic [15:0]     sram_dq_o, sram_dq_i;

   always #5 clk = ~clk;

   mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .fault(fault), .sram_addr(sram_addr),
      .sram_we_n(sram_we_n), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
      .sram_dq_i(sram_dq_i)
   );

   bit [15:0] sram_mem [0:(1<<AW)-1];
   bit [15:0] ref_mem  [0:(1<<AW)-1];

   assign sram_dq_i = sram_mem[sram_addr];
   always @(posedge clk) if (sram_we_n === 1'b0) sram_mem[sram_addr] <= sram_dq_o;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit is_fault(input logic [31:0] a);
`ifdef MEM_FAULT_EN
      logic [31:0] o;
      o = (a - BASE) >> 2;
      return (a[1:0] != 2'b00) || (a < BASE) || (o >= (32'd1 << (AW-1)));
`else
      return (a === 32'hxxxx_xxxx);
`endif
   endfunction

   function automatic logic [AW-2:0] idx_of(input logic [31:0] a);
      logic [31:0] o;
      o = (a - BASE) >> 2;
      return o[AW-2:0];
   endfunction

   // Reference: t counts cycles since acceptance (0 = idle); phases follow from t alone.
   int            t;
   bit            m_wr, m_fault;
   logic [AW-2:0] m_idx;
   logic [31:0]   m_wdata, m_rdata;
   logic [AW-1:0] m_addr;
   logic [15:0]   m_dq;

   initial begin
      bit in_lo, in_hi, act;
      t = 0; m_wr = 0; m_fault = 0; m_idx = '0; m_wdata = '0;
      m_rdata = '0; m_addr = '0; m_dq = '0;
      wait (chk_on);
      forever begin
         @(negedge clk);
         in_lo = (t >= 1) && (t <= W);
         in_hi = (t > W) && (t <= 2*W);
         act   = in_lo || in_hi;
         if (in_lo) begin
            m_addr = {m_idx, 1'b0};
            if (m_wr) m_dq = m_wdata[15:0];
         end
         if (in_hi) begin
            m_addr = {m_idx, 1'b1};
            if (m_wr) m_dq = m_wdata[31:16];
         end
         if (t == 2*W+1 && !m_wr && !m_fault)
            m_rdata = {ref_mem[{m_idx, 1'b1}], ref_mem[{m_idx, 1'b0}]};
         check("ready", 32'(ready), (t == 0) ? 32'(!(rd_en || wr_en)) : 32'(t == 2*W+1));
         check("we_n", 32'(sram_we_n), 32'(!(act && m_wr)));
         check("dq_oe", 32'(sram_dq_oe), 32'(act && m_wr));
         check("sram_addr", 32'(sram_addr), 32'(m_addr));
         check("dq_o", 32'(sram_dq_o), 32'(m_dq));
         check("rdata", rdata, m_rdata);
         check("fault", 32'(fault), 32'((t == 2*W+1) && m_fault));
         if (act && m_wr) ref_mem[m_addr] = m_dq;
         if (rst) begin
            t = 0; m_rdata = '0; m_addr = '0; m_dq = '0;
         end else if (t == 0) begin
            if (rd_en || wr_en) begin
               m_wr    = wr_en;
               m_idx   = idx_of(addr);
               m_wdata = wdata;
               m_fault = is_fault(addr);
               t       = m_fault ? 2*W+1 : 1;
            end
         end else if (t == 2*W+1) begin
            t = 0;
         end else begin
            t++;
         end
      end
   end

   task automatic start(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      rd_en = rd; wr_en = wr; addr = a; wdata = d;
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      rd_en = 0; wr_en = 0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < 4*W+4);
      if (!ready) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout: ready still %b after %0d cycles, required 1", ready, n);
      end
   endtask

   initial begin
      rst = 1; rd_en = 0; wr_en = 0; addr = '0; wdata = '0;
      @(posedge clk); #1 chk_on = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_we_n", 32'(sram_we_n), 32'd1);
      check("idle_oe", 32'(sram_dq_oe), 32'd0);
      check("idle_rdata", rdata, 32'd0);

      start(0, 1, 32'd1032, 32'hDEADBEEF);
      for (int c = 0; c <= 2*W+1; c++) begin
         @(negedge clk);
         if (c == 1 || c == 2) begin
            check("st_lo_addr", 32'(sram_addr), 32'd4);
            check("st_lo_dq", 32'(sram_dq_o), 32'h0000BEEF);
            check("st_lo_we_n", 32'(sram_we_n), 32'd0);
         end
         if (c == 3 || c == 4) begin
            check("st_hi_addr", 32'(sram_addr), 32'd5);
            check("st_hi_dq", 32'(sram_dq_o), 32'h0000DEAD);
         end
         if (c < 5) check("st_ready_low", 32'(ready), 32'd0);
         if (c == 5) check("st_ready_c5", 32'(ready), 32'd1);
      end
      go_idle();

      start(1, 0, 32'd1032, 32'd0);
      for (int c = 0; c <= 2*W+1; c++) begin
         @(negedge clk);
         check("ld_we_n", 32'(sram_we_n), 32'd1);
         if (c == 5) begin
            check("ld_rdata", rdata, 32'hDEADBEEF);
            check("ld_ready_c5", 32'(ready), 32'd1);
         end
      end
      go_idle();

      start(1, 1, 32'd1024, 32'h12345678);
      repeat (2*W+2) @(negedge clk);
      go_idle();
      @(negedge clk);
      check("both_mem0", 32'(sram_mem[0]), 32'h5678);
      check("both_mem1", 32'(sram_mem[1]), 32'h1234);
      check("both_rdata", rdata, 32'hDEADBEEF);

      start(0, 1, 32'd1036, 32'hCAFEF00D);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst = 1; wr_en = 0;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe", 32'(sram_dq_oe), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_rdata", rdata, 32'd0);

`ifdef MEM_FAULT_EN
      start(1, 0, 32'd1026, 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("flt_fault", 32'(fault), 32'd1);
      check("flt_ready", 32'(ready), 32'd1);
      check("flt_we_n", 32'(sram_we_n), 32'd1);
      check("flt_rdata", rdata, 32'd0);
      go_idle();
`else
      start(1, 0, 32'd1026, 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("mis_lo_addr", 32'(sram_addr), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("mis_hi_addr", 32'(sram_addr), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("mis_rdata", rdata, 32'h12345678);
      go_idle();
`endif

      for (int i = 0; i < 400; i++) begin
         int          kind, op;
         logic [31:0] a;
         if ($urandom_range(0, 3) == 0) begin
            go_idle();
            repeat ($urandom_range(0, 2)) @(posedge clk);
         end
         if (i > 0 && $urandom_range(0, 4) == 0 && (rd_en || wr_en)) begin
            @(posedge clk); #1;
         end else begin
            kind = $urandom_range(0, 9);
            a    = BASE + 4 * $urandom_range(0, 15);
            if (kind == 0) a = a + (32'd1 << (AW+1)) * $urandom_range(1, 3);
            if (kind == 1) a = a + 32'($urandom_range(1, 3));
            if (kind == 2) a = 32'($urandom_range(0, BASE-1));
            op = $urandom_range(0, 2);
            start(op != 1, op != 0, a, $urandom);
         end
         wait_done();
      end
      go_idle();
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end
endmodule
